// File: rtl/ps2_pkt_pkg.sv
// Shared types and constants for the PS/2 packet transmitter.
// Marker-bit helper used for both the frame marker and the filler byte.
package ps2_pkt_pkg;

  localparam int BYTE_W    = 8;
  localparam int MSG_W     = 24;
  localparam int MARK_BIT  = 3;
  localparam int PKT_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B3   = 3'd3,
    GAP  = 3'd4
  } tx_state_t;

  function automatic logic [BYTE_W-1:0] set_mark(input logic [BYTE_W-1:0] b, input logic v);
    logic [BYTE_W-1:0] r;
    r           = b;
    r[MARK_BIT] = v;
    return r;
  endfunction

endpackage

// File: rtl/ps2_packet_tx_buf.sv
// One-entry valid/ready holding register in front of the packet serialiser.
// pop and accept never coincide: accept needs empty, pop needs full.
module ps2_msg_buf
  import ps2_pkt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [MSG_W-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [MSG_W-1:0] q,
  output logic             q_full,
  input  logic             pop
);

  logic             full_r;
  logic [MSG_W-1:0] data_r;

  assign d_ready = !full_r;
  assign q       = data_r;
  assign q_full  = full_r;

  // Holding register: capture on accept, release on pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 1'b0;
      data_r <= {MSG_W{1'b0}};
    end else if (pop) begin
      full_r <= 1'b0;
    end else if (d_valid && !full_r) begin
      full_r <= 1'b1;
      data_r <= d;
    end
  end

endmodule

// File: rtl/ps2_packet_tx.sv
// PS/2 3-byte packet transmitter: buffered message in, framed byte stream out.
// Outputs are computed from the next state so they are registered yet on time.
module ps2_packet_tx
  import ps2_pkt_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = 8'h00,
  parameter int         GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MSG_W-1:0]  msg_in,
  input  logic              msg_valid,
  output logic              msg_ready,
  output logic [BYTE_W-1:0] out,
  output logic              out_valid,
  output logic              sent,
  output logic              busy
);

  localparam logic [3:0]        GAP_N  = 4'(GAP_CYCLES);
  localparam logic [BYTE_W-1:0] FILLER = set_mark(IDLE_BYTE, 1'b0);

  tx_state_t         state_r, next_state_s;
  logic [MSG_W-1:0]  shift_r, next_shift_s;
  logic [3:0]        gap_cnt_r, next_gap_s;
  logic [MSG_W-1:0]  buf_q_s;
  logic              buf_full_s, pop_s, next_full_s;
  logic [BYTE_W-1:0] out_r, next_out_s;
  logic              out_valid_r, next_out_valid_s;
  logic              sent_r, next_sent_s;
  logic              busy_r;

  ps2_msg_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .d       (msg_in),
    .d_valid (msg_valid),
    .d_ready (msg_ready),
    .q       (buf_q_s),
    .q_full  (buf_full_s),
    .pop     (pop_s)
  );

  // Next-state, buffer drain, shift and gap count.
  always_comb begin
    next_state_s = state_r;
    next_shift_s = shift_r;
    next_gap_s   = gap_cnt_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (buf_full_s) begin
          next_state_s = B1;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      B1: begin
        next_state_s = B2;
        next_shift_s = {shift_r[MSG_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end
      B2: begin
        next_state_s = B3;
        next_shift_s = {shift_r[MSG_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      end
      B3: begin
        if (GAP_N != 4'd0) begin
          next_state_s = GAP;
          next_gap_s   = 4'd1;
        end else if (buf_full_s) begin
          next_state_s = B1;
          pop_s        = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_r >= GAP_N) begin
          if (buf_full_s) begin
            next_state_s = B1;
            pop_s        = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_gap_s = gap_cnt_r + 4'd1;
        end
      end
      default: next_state_s = IDLE;
    endcase
    if (pop_s) begin
      next_shift_s = buf_q_s;
    end else begin
      next_shift_s = next_shift_s;
    end
  end

  // Output byte for the state being entered; the top byte of the shift register is current.
  always_comb begin
    next_out_s       = FILLER;
    next_out_valid_s = 1'b0;
    next_sent_s      = 1'b0;
    case (next_state_s)
      B1: begin
        next_out_s       = set_mark(next_shift_s[MSG_W-1 -: BYTE_W], 1'b1);
        next_out_valid_s = 1'b1;
      end
      B2: begin
        next_out_s       = next_shift_s[MSG_W-1 -: BYTE_W];
        next_out_valid_s = 1'b1;
      end
      B3: begin
        next_out_s       = next_shift_s[MSG_W-1 -: BYTE_W];
        next_out_valid_s = 1'b1;
        next_sent_s      = 1'b1;
      end
      default: next_out_s = FILLER;
    endcase
    next_full_s = (buf_full_s && !pop_s) || (msg_valid && msg_ready);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      shift_r     <= {MSG_W{1'b0}};
      gap_cnt_r   <= 4'd0;
      out_r       <= FILLER;
      out_valid_r <= 1'b0;
      sent_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      shift_r     <= next_shift_s;
      gap_cnt_r   <= next_gap_s;
      out_r       <= next_out_s;
      out_valid_r <= next_out_valid_s;
      sent_r      <= next_sent_s;
      busy_r      <= (next_state_s != IDLE) || next_full_s;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign sent      = sent_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_ps2_packet_tx.sv
// Self-checking bench for ps2_packet_tx: default, GAP_CYCLES=2 and IDLE_BYTE=FF instances.
module tb_ps2_packet_tx;

  typedef struct {
    logic [23:0] msg;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] msg_in    [3];
  logic        msg_valid [3];
  logic        msg_ready [3];
  logic [7:0]  out_b     [3];
  logic        out_vld   [3];
  logic        sent_b    [3];
  logic        busy_b    [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0] cap_out [16];
  logic       cap_val [16];
  logic       cap_rdy [16];
  int         cap_sent;

  always #5 clk = ~clk;

  ps2_packet_tx u0 (
    .clk(clk), .reset(reset), .msg_in(msg_in[0]), .msg_valid(msg_valid[0]),
    .msg_ready(msg_ready[0]), .out(out_b[0]), .out_valid(out_vld[0]),
    .sent(sent_b[0]), .busy(busy_b[0]));

  ps2_packet_tx #(.GAP_CYCLES(2)) u1 (
    .clk(clk), .reset(reset), .msg_in(msg_in[1]), .msg_valid(msg_valid[1]),
    .msg_ready(msg_ready[1]), .out(out_b[1]), .out_valid(out_vld[1]),
    .sent(sent_b[1]), .busy(busy_b[1]));

  ps2_packet_tx #(.IDLE_BYTE(8'hFF)) u2 (
    .clk(clk), .reset(reset), .msg_in(msg_in[2]), .msg_valid(msg_valid[2]),
    .msg_ready(msg_ready[2]), .out(out_b[2]), .out_valid(out_vld[2]),
    .sent(sent_b[2]), .busy(busy_b[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold msg_valid until each message is accepted; capture outputs after every edge.
  task automatic run_stream(input int d, input int nmsg, input logic [23:0] m0,
                            input logic [23:0] m1, input int ncyc);
    int   idx;
    logic rdy;
    idx      = 0;
    cap_sent = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < nmsg) begin
        msg_valid[d] = 1'b1;
        msg_in[d]    = (idx == 0) ? m0 : m1;
      end else begin
        msg_valid[d] = 1'b0;
      end
      rdy = msg_ready[d];
      tick();
      if (msg_valid[d] && rdy) idx++;
      cap_out[c] = out_b[d];
      cap_val[c] = out_vld[d];
      cap_rdy[c] = msg_ready[d];
      if (sent_b[d]) cap_sent++;
    end
    msg_valid[d] = 1'b0;
  endtask

  vec_t vecs [4];
  logic [7:0] exp3_out [7];
  logic       exp3_val [7];
  logic [7:0] exp4_out [9];
  logic       exp4_val [9];

  initial begin
    vecs[0] = '{msg: 24'h2A_55_81, b1: 8'h2A, b2: 8'h55, b3: 8'h81};
    vecs[1] = '{msg: 24'h10_FF_08, b1: 8'h18, b2: 8'hFF, b3: 8'h08};
    vecs[2] = '{msg: 24'h08_AA_BB, b1: 8'h08, b2: 8'hAA, b3: 8'hBB};
    vecs[3] = '{msg: 24'h00_08_F7, b1: 8'h08, b2: 8'h08, b3: 8'hF7};
    exp3_out = '{8'h08, 8'h01, 8'h02, 8'h0C, 8'h03, 8'h04, 8'h00};
    exp3_val = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp4_out = '{8'h08, 8'h01, 8'h02, 8'h00, 8'h00, 8'h0C, 8'h03, 8'h04, 8'h00};
    exp4_val = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      msg_in[d]    = 24'h00_00_00;
      msg_valid[d] = 1'b0;
    end
    tick(); tick(); tick();
    chk("rst_out0", {24'h0, out_b[0]}, 32'h00);
    chk("rst_out2", {24'h0, out_b[2]}, 32'hF7);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_flags%0d", d), {29'h0, out_vld[d], sent_b[d], busy_b[d]}, 32'h0);
    end
    reset = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) chk($sformatf("rst_ready%0d", d), {31'h0, msg_ready[d]}, 32'h1);

    // Single packets through the default instance.
    for (int v = 0; v < 4; v++) begin
      msg_in[0]    = vecs[v].msg;
      msg_valid[0] = 1'b1;
      tick();
      msg_valid[0] = 1'b0;
      chk($sformatf("v%0d_acc", v), {29'h0, out_vld[0], msg_ready[0], busy_b[0]}, 32'h1);
      tick();
      chk($sformatf("v%0d_b1", v), {22'h0, out_vld[0], sent_b[0], out_b[0]}, {22'h0, 2'b10, vecs[v].b1});
      tick();
      chk($sformatf("v%0d_b2", v), {22'h0, out_vld[0], sent_b[0], out_b[0]}, {22'h0, 2'b10, vecs[v].b2});
      tick();
      chk($sformatf("v%0d_b3", v), {22'h0, out_vld[0], sent_b[0], out_b[0]}, {22'h0, 2'b11, vecs[v].b3});
      tick();
      chk($sformatf("v%0d_idle", v), {21'h0, out_vld[0], sent_b[0], busy_b[0], out_b[0]}, 32'h0);
    end

    // Back-to-back, no gap.
    run_stream(0, 2, 24'h08_01_02, 24'h0C_03_04, 8);
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("b2b_c%0d", c), {23'h0, cap_val[c], cap_out[c]}, {23'h0, exp3_val[c-1], exp3_out[c-1]});
    end
    chk("b2b_full_after_acc", {31'h0, cap_rdy[0]}, 32'h0);
    chk("b2b_drain_ready", {31'h0, cap_rdy[3]}, 32'h0);
    chk("b2b_sent_count", cap_sent, 32'd2);

    // Same pair with two filler cycles between packets.
    run_stream(1, 2, 24'h08_01_02, 24'h0C_03_04, 10);
    for (int c = 1; c < 10; c++) begin
      chk($sformatf("gap_c%0d", c), {23'h0, cap_val[c], cap_out[c]}, {23'h0, exp4_val[c-1], exp4_out[c-1]});
    end
    chk("gap_sent_count", cap_sent, 32'd2);

    // Filler with IDLE_BYTE=FF has the marker bit cleared.
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fill_ff_c%0d", c), {23'h0, out_vld[2], out_b[2]}, 32'h0F7);
      tick();
    end

    // Reset during B2 with a second message buffered.
    msg_in[0]    = 24'h08_AA_BB;
    msg_valid[0] = 1'b1;
    tick();
    msg_in[0] = 24'h11_22_33;
    tick();
    chk("mid_b1", {24'h0, out_b[0]}, 32'h08);
    tick();
    msg_valid[0] = 1'b0;
    chk("mid_b2", {23'h0, out_vld[0], out_b[0]}, 32'h1AA);
    chk("mid_buf_full", {31'h0, msg_ready[0]}, 32'h0);
    reset = 1'b1;
    tick();
    chk("mid_rst_out", {21'h0, out_vld[0], sent_b[0], busy_b[0], out_b[0]}, 32'h0);
    reset = 1'b0;
    tick();
    chk("mid_ready", {31'h0, msg_ready[0]}, 32'h1);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("mid_quiet_c%0d", c), {21'h0, out_vld[0], sent_b[0], busy_b[0], out_b[0]}, 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
